// File: rtl/rand_range_gen.sv
// On-request random draw in 1..RANGE from a free-running Fibonacci LFSR, valid/ready output.
// Define RAND_UNIFORM_EN for rejection sampling (exact uniformity); otherwise a plain fold is used.
module rand_range_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'h1D,
    parameter logic [WIDTH-1:0] SEED  = 'h01,
    parameter int               RANGE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic             busy
);

    localparam int               LIMIT_I = ((2**WIDTH - 1) / RANGE) * RANGE;
    localparam logic [WIDTH-1:0] LIMIT   = LIMIT_I[WIDTH-1:0];

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_step;
    logic             accept;
    logic [WIDTH-1:0] map_rom [2**WIDTH];

    // Fold table built from constants, so the mapping costs a ROM lookup instead of a divider.
    for (genvar i = 0; i < 2**WIDTH; i++) begin : g_map
        localparam int M = (i == 0) ? 0 : ((i - 1) % RANGE) + 1;
        assign map_rom[i] = M[WIDTH-1:0];
    end

    assign lfsr_step = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
    assign busy      = (state != IDLE);

`ifdef RAND_UNIFORM_EN
    assign accept = (lfsr <= LIMIT);
`else
    assign accept = 1'b1;
`endif

    always_comb begin
        state_d = state;
        if (seed_load) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (req) state_d = RUN;
                RUN:     if (accept) state_d = HOLD;
                HOLD:    if (out_ready) state_d = req ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            out_valid <= 1'b0;
            out_val   <= '0;
        end else begin
            state <= state_d;
            if (seed_load) begin
                lfsr      <= (seed_val == '0) ? SEED : seed_val;
                out_valid <= 1'b0;
            end else begin
                lfsr <= lfsr_step;
                if (state == RUN && accept) begin
                    out_valid <= 1'b1;
                    out_val   <= map_rom[lfsr];
                end else if (state == HOLD && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/rand_range_gen.md
# rand_range_gen

Parametrised pseudo-random number source for game logic. It draws uniformly distributed values in 1..RANGE from a free-running Fibonacci LFSR of configurable width and taps. Draws are made on request, use a valid/ready output handshake, and the seed can be loaded at run time. Consumers include spawn position, enemy choice and tile selection; each consumer instantiates its own copy with its own RANGE and SEED.

## Interface
- WIDTH, 8: LFSR width in bits, legal range 4..16.
- TAPS, 8'h1D: feedback mask. Bit k set means state[k] is XORed into the new MSB. The default is maximal-length for WIDTH=8.
- SEED, 8'h01: reset and fallback seed. Must be non-zero.
- RANGE, 8: upper bound of the output, legal range 1..2^WIDTH-1.
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- seed_load  input  1  load seed_val into the LFSR and abort any draw.
- seed_val  input  WIDTH  seed value. Zero is replaced by SEED.
- req  input  1  request one draw. Level-sampled in IDLE, and in HOLD on a transfer cycle.
- out_valid  output  1  out_val holds a completed draw.
- out_ready  input  1  consumer accepts out_val.
- out_val  output  WIDTH  drawn value, 1..RANGE.
- busy  output  1  FSM is not in IDLE.

## Operation
- LFSR step: lfsr <= {^(lfsr & TAPS), lfsr[WIDTH-1:1]}.
- The LFSR steps on every clock edge in every FSM state, except when seed_load is high.
- Because the LFSR free-runs, request timing adds entropy.
- The all-zero state is unreachable: reset, step and load never produce zero.
- Derived constants: K = floor((2^WIDTH-1)/RANGE), LIMIT = K*RANGE.
- Mapping: map(x) = ((x-1) mod RANGE) + 1. It is evaluated on parameter constants only, with no runtime divider.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - req=1 -> RUN.
- RUN: each cycle the current lfsr is the candidate.
  - Accept: out_val <= map(lfsr), out_valid <= 1, go to HOLD.
  - Reject: stay in RUN. The LFSR advances, so the next cycle has a fresh candidate.
- HOLD: out_val and out_valid are held stable while out_ready=0.
  - out_ready=1 and req=0 -> IDLE, out_valid <= 0.
  - out_ready=1 and req=1 -> RUN, out_valid <= 0. This gives back-to-back draws.
- seed_load=1 (highest priority after rst):
  - lfsr <= (seed_val==0 ? SEED : seed_val).
  - FSM -> IDLE, out_valid <= 0.
  - req is ignored on that cycle.
- busy = (state != IDLE).

## Timing
- Reset values: lfsr=SEED, state=IDLE, out_valid=0, out_val=0, busy=0.
- Reset asserted mid-draw clears everything immediately (asynchronous). No pending draw survives.
- Latency from the req sample edge to out_valid high:
  - 2 edges when the first candidate is accepted.
  - plus 1 edge per rejected candidate.
- Reject worst case is bounded by the LFSR period, 2^WIDTH-1 edges.
- Transfer occurs on the edge where out_valid & out_ready are both high.
- out_valid never rises on the same edge as a transfer.

## Configuration
- RAND_UNIFORM_EN defined:
  - Rejection sampling. A candidate is accepted iff lfsr <= LIMIT.
  - The output is exactly uniform over the LFSR period.
- RAND_UNIFORM_EN undefined:
  - Every candidate is accepted (fold only). Latency is always 2 edges.
  - Slight bias toward low values when RANGE does not divide 2^WIDTH-1.

## Test plan
Bench parameters: WIDTH=4, TAPS=4'h3, SEED=4'h8, RANGE=8. LFSR sequence: 8,4,2,9,C,6,B,5,A,D,E,F,7,3,1,8. For this configuration K=1 and LIMIT=8.

- Basic draw: release reset with req=1 and out_ready=0 -> RUN at edge 1 (lfsr=4), out_valid=1 with out_val=4 after edge 2, busy=1.
- Rejection:
  - Stimulus: load seed 6, then req -> RUN with lfsr=B.
  - With RAND_UNIFORM_EN: B is rejected, out_val=5 one edge later (3 edges total).
  - Without RAND_UNIFORM_EN: out_val=3 after 2 edges.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_val and out_valid are stable. Raising out_ready with req=0 -> IDLE next edge, out_valid=0.
- Back-to-back: out_ready=1 and req=1 held continuously -> one transfer every 2 edges when there are no rejections. No cycle with out_valid=0 while in HOLD.
- Zero seed and abort: seed_load with seed_val=0 during RUN -> lfsr=8, state IDLE, out_valid=0, no output produced.
- Reset mid-draw: assert rst between edges while in RUN -> out_valid=0, busy=0, lfsr=8 immediately, without waiting for a clock edge.
